// File: rtl/chunk_feeder.sv
// Key/nonce/counter word store that answers ChaCha20 chunk requests with single-cycle beats.
// Optional counter auto-increment on block_done is enabled by defining CHUNK_FEEDER_CTR_AUTOINC_EN.
module chunk_feeder #(
  parameter logic [31:0] CTR_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wipe,
  input  logic        lock,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  input  logic        block_done,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic [11:0] loaded,
  output logic        all_loaded,
  output logic        err,
  output logic        ctr_wrap
);

  localparam int NWORDS = 12;
  localparam logic [3:0] CTR_ADDR = 4'd11;

  logic [31:0] store [NWORDS];
  logic [11:0] loaded_reg;
  logic        err_reg;
  logic        ctr_wrap_reg;
  logic        chunk_valid_reg;
  logic [1:0]  chunk_type_reg;
  logic [31:0] chunk_reg;

  logic        wr_accept;
  logic        wr_reject;
  logic        req_legal;
  logic [3:0]  req_addr;
  logic        req_live;
  logic        req_service;
  logic        req_illegal;
  logic        ctr_inc;
  logic [32:0] ctr_sum;

  assign wr_accept = wr_en && !lock && (wr_addr < 4'd12);
  assign wr_reject = wr_en && !wr_accept;

  always_comb begin
    req_legal = 1'b0;
    req_addr  = 4'd0;
    case (request_type)
      2'd0: begin
        req_legal = (chunk_index <= 5'd7);
        req_addr  = {1'b0, chunk_index[2:0]};
      end
      2'd1: begin
        req_legal = (chunk_index <= 5'd2);
        req_addr  = 4'd8 + {2'b00, chunk_index[1:0]};
      end
      2'd2: begin
        req_legal = (chunk_index == 5'd0);
        req_addr  = CTR_ADDR;
      end
      default: begin
        req_legal = 1'b0;
        req_addr  = 4'd0;
      end
    endcase
  end

  // Requests arriving while a beat is on the bus are not looked at at all.
  assign req_live    = chunk_request && !chunk_valid_reg;
  assign req_service = req_live && req_legal && loaded_reg[req_addr];
  assign req_illegal = req_live && !req_legal;

`ifdef CHUNK_FEEDER_CTR_AUTOINC_EN
  assign ctr_sum = {1'b0, store[CTR_ADDR]} + {1'b0, CTR_STEP};
  // A host write to the counter in the same cycle overrides the increment.
  assign ctr_inc = block_done && loaded_reg[CTR_ADDR] &&
                   !(wr_accept && (wr_addr == CTR_ADDR));
`else
  logic unused_cfg;
  assign unused_cfg = ^{block_done, CTR_STEP};
  assign ctr_sum    = {1'b0, store[CTR_ADDR]};
  assign ctr_inc    = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [31:0] word_reg;
      logic        hit;
      assign hit = wr_accept && (wr_addr == 4'(gi));
      if (gi == NWORDS - 1) begin : g_ctr
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       word_reg <= '0;
          else if (wipe)    word_reg <= '0;
          else if (hit)     word_reg <= wr_data;
          else if (ctr_inc) word_reg <= ctr_sum[31:0];
        end
      end else begin : g_plain
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)    word_reg <= '0;
          else if (wipe) word_reg <= '0;
          else if (hit)  word_reg <= wr_data;
        end
      end
      assign store[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_reg      <= '0;
      err_reg         <= 1'b0;
      ctr_wrap_reg    <= 1'b0;
      chunk_valid_reg <= 1'b0;
      chunk_type_reg  <= 2'b00;
      chunk_reg       <= '0;
    end else if (wipe) begin
      loaded_reg      <= '0;
      err_reg         <= 1'b0;
      ctr_wrap_reg    <= 1'b0;
      chunk_valid_reg <= 1'b0;
      chunk_type_reg  <= 2'b00;
      chunk_reg       <= '0;
    end else begin
      chunk_valid_reg <= req_service;
      if (req_service) begin
        chunk_type_reg <= request_type;
        chunk_reg      <= store[req_addr];
      end
      if (wr_accept) loaded_reg[wr_addr] <= 1'b1;
      if (wr_reject || req_illegal) err_reg <= 1'b1;
      if (wr_accept && (wr_addr == CTR_ADDR)) ctr_wrap_reg <= 1'b0;
      else if (ctr_inc && ctr_sum[32])        ctr_wrap_reg <= 1'b1;
    end
  end

  assign chunk_valid = chunk_valid_reg;
  assign chunk_type  = chunk_type_reg;
  assign chunk       = chunk_reg;
  assign loaded      = loaded_reg;
  assign all_loaded  = &loaded_reg;
  assign err         = err_reg;
  assign ctr_wrap    = ctr_wrap_reg;

endmodule

// File: tb/tb_chunk_feeder.sv
// Scoreboard bench for chunk_feeder: a word-array reference model predicts beats and flags,
// a negedge monitor pops expected beats. Honors CHUNK_FEEDER_CTR_AUTOINC_EN like the RTL.
module tb_chunk_feeder;

  localparam logic [31:0] STEP = 32'd1;
`ifdef CHUNK_FEEDER_CTR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wipe = 1'b0, lock = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        chunk_request = 1'b0;
  logic [1:0]  request_type = '0;
  logic [4:0]  chunk_index = '0;
  logic        block_done = 1'b0;
  logic        chunk_valid;
  logic [1:0]  chunk_type;
  logic [31:0] chunk;
  logic [11:0] loaded;
  logic        all_loaded, err, ctr_wrap;

  chunk_feeder #(.CTR_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .wipe(wipe), .lock(lock), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .chunk_request(chunk_request),
    .request_type(request_type), .chunk_index(chunk_index), .block_done(block_done),
    .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk),
    .loaded(loaded), .all_loaded(all_loaded), .err(err), .ctr_wrap(ctr_wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    int          at;
    logic [1:0]  t;
    logic [31:0] d;
  } beat_t;
  beat_t exp_q[$];

  // Reference model state
  logic [31:0] m_store [12];
  logic [11:0] m_loaded;
  logic        m_err, m_wrap, m_valid;
  logic [1:0]  m_type;
  logic [31:0] m_chunk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 12; i++) m_store[i] = '0;
    m_loaded = '0; m_err = 0; m_wrap = 0; m_valid = 0; m_type = '0; m_chunk = '0;
  endtask

  // Predict the effect of the upcoming clock edge from the inputs now applied.
  task automatic model_edge();
    bit legal, acc, serviced;
    int a, t, idx;
    longint s;
    if (wipe) begin
      model_clear();
      return;
    end
    serviced = 0;
    t = int'(request_type);
    idx = int'(chunk_index);
    if (chunk_request && !m_valid) begin
      legal = (t == 0 && idx < 8) || (t == 1 && idx < 3) || (t == 2 && idx == 0);
      a = (t == 0) ? idx : (t == 1) ? 8 + idx : 11;
      if (!legal) m_err = 1;
      else if (m_loaded[a]) begin
        serviced = 1;
        m_type = request_type;
        m_chunk = m_store[a];
        exp_q.push_back('{at: cyc + 1, t: request_type, d: m_store[a]});
      end
    end
    acc = wr_en && !lock && (int'(wr_addr) < 12);
    if (wr_en && !acc) m_err = 1;
    if (AUTOINC && block_done && m_loaded[11] && !(acc && int'(wr_addr) == 11)) begin
      s = longint'(m_store[11]) + longint'(STEP);
      if (s > 64'hFFFF_FFFF) m_wrap = 1;
      m_store[11] = s[31:0];
    end
    if (acc) begin
      m_store[wr_addr] = wr_data;
      m_loaded[wr_addr] = 1'b1;
      if (int'(wr_addr) == 11) m_wrap = 0;
    end
    m_valid = serviced;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("loaded", 32'(loaded), 32'(m_loaded));
    chk("all_loaded", 32'(all_loaded), 32'(&m_loaded));
    chk("err", 32'(err), 32'(m_err));
    chk("ctr_wrap", 32'(ctr_wrap), 32'(m_wrap));
    chk("chunk_valid", 32'(chunk_valid), 32'(m_valid));
    chk("chunk_hold", chunk, m_chunk);
    chk("type_hold", 32'(chunk_type), 32'(m_type));
  endtask

  task automatic idle();
    wipe = 0; lock = 0; wr_en = 0; chunk_request = 0; block_done = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = 4'(a); wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic req(input int t, input int idx);
    chunk_request = 1; request_type = 2'(t); chunk_index = 5'(idx);
    step();
    chunk_request = 0;
    step();
  endtask

  // Monitor: each beat must match the oldest prediction, on the predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chunk_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL beat_unexpected at cycle %0d: got data %h, none expected", cyc, chunk);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_cycle", 32'(cyc), 32'(e.at));
          chk("beat_type", 32'(chunk_type), 32'(e.t));
          chk("beat_data", chunk, e.d);
        end
      end else if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
        n_vec++; n_fail++;
        $display("FAIL beat_missing at cycle %0d: got no beat, expected data %h", cyc, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    model_clear();
    #3;
    chk("rst_valid", 32'(chunk_valid), 32'd0);
    chk("rst_chunk", chunk, 32'd0);
    chk("rst_type", 32'(chunk_type), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_flags", {29'd0, all_loaded, err, ctr_wrap}, 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // Load and stream
    for (int a = 0; a < 12; a++) wr(a, 32'h1000_0000 + 32'(a));
    chk("all_loaded_after_load", 32'(all_loaded), 32'd1);
    for (int i = 0; i < 8; i++) req(0, i);
    for (int i = 0; i < 3; i++) req(1, i);
    req(2, 0);

    // Stall on an unloaded word
    wipe = 1; step(); wipe = 0;
    for (int a = 0; a < 10; a++) wr(a, $urandom);
    chunk_request = 1; request_type = 2'd1; chunk_index = 5'd2;
    repeat (3) step();
    chk("stall_no_err", 32'(err), 32'd0);
    wr_en = 1; wr_addr = 4'd10; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 0;
    step();
    chk("stall_beat", chunk, 32'hDEAD_BEEF);
    chunk_request = 0;
    step();

    // Illegal accesses
    req(3, 0);
    chk("err_type3", 32'(err), 32'd1);
    wipe = 1; step(); wipe = 0;
    req(1, 3);
    chk("err_idx", 32'(err), 32'd1);
    wipe = 1; step(); wipe = 0;
    wr(4, 32'h0000_1234);
    wr(12, 32'hBAD0_0000);
    chk("err_addr12", 32'(err), 32'd1);
    lock = 1; wr(4, 32'hBAD1_1111); lock = 0;
    req(0, 4);
    chk("locked_store", chunk, 32'h0000_1234);
    wipe = 1; step(); wipe = 0;
    chk("wipe_err", 32'(err), 32'd0);
    chk("wipe_loaded", 32'(loaded), 32'd0);

    // Counter increment and wrap
    wr(11, 32'hFFFF_FFFE);
    block_done = 1; step(); block_done = 0;
    req(2, 0);
    chk("ctr_first", chunk, AUTOINC ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
    block_done = 1; step(); block_done = 0;
    req(2, 0);
    chk("ctr_second", chunk, AUTOINC ? 32'h0000_0000 : 32'hFFFF_FFFE);
    chk("ctr_wrap_set", 32'(ctr_wrap), AUTOINC ? 32'd1 : 32'd0);
    block_done = 1; wr(11, 32'd5); block_done = 0;
    req(2, 0);
    chk("ctr_host_wins", chunk, 32'd5);
    chk("ctr_wrap_clr", 32'(ctr_wrap), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      wipe = ($urandom_range(63) == 0);
      lock = ($urandom_range(7) == 0);
      wr_en = ($urandom_range(2) == 0);
      wr_addr = ($urandom_range(5) == 0) ? 4'($urandom_range(15, 12)) : 4'($urandom_range(11));
      wr_data = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      chunk_request = $urandom_range(1);
      request_type = 2'($urandom_range(3));
      chunk_index = ($urandom_range(5) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(2));
      block_done = ($urandom_range(3) == 0);
      step();
    end
    idle();
    step();

    // Async reset during a beat
    wr(0, 32'hCAFE_0001);
    chunk_request = 1; request_type = 2'd0; chunk_index = 5'd0;
    step();
    chunk_request = 0;
    chk("pre_reset_beat", 32'(chunk_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("areset_valid", 32'(chunk_valid), 32'd0);
    chk("areset_chunk", chunk, 32'd0);
    chk("areset_loaded", 32'(loaded), 32'd0);
    chk("areset_flags", {28'd0, chunk_type, err, ctr_wrap}, 32'd0);
    exp_q.delete();
    model_clear();
    @(posedge clk); #1 rst_n = 1;
    chunk_request = 1; request_type = 2'd0; chunk_index = 5'd0;
    repeat (3) step();
    chunk_request = 0;
    wr(0, 32'h0BAD_F00D);
    req(0, 0);
    chk("post_reset_beat", chunk, 32'h0BAD_F00D);

    step(); step();
    if (exp_q.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL beats_outstanding: got %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
